// File: rtl/joybus_tx_frame_if.sv
// Request/status bundle between a Joybus frame requester and the line transmitter.
interface joybus_tx_frame_if #(
  parameter int unsigned MAX_BYTES = 8
);
  localparam int unsigned LW = $clog2(MAX_BYTES + 1);
  localparam int unsigned DW = 8 * MAX_BYTES;

  logic [DW-1:0] tx_data;
  logic [LW-1:0] tx_len;
  logic          stop_mode;
  logic          tx_start;
  logic          auto_arm;
  logic          rx_done;
  logic          jb_tx;
  logic          jb_tx_sel;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_err;

  modport master (
    output tx_data, tx_len, stop_mode, tx_start, auto_arm, rx_done,
    input  jb_tx, jb_tx_sel, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_len, stop_mode, tx_start, auto_arm, rx_done,
    output jb_tx, jb_tx_sel, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/joybus_tx_frame.sv
// Joybus frame transmitter: 1..MAX_BYTES bytes MSB first, then a console or
// controller stop bit; optional auto-reply after a bus turnaround gap.
module joybus_tx_frame #(
  parameter int unsigned US_CYC    = 25,
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned TURN_CYC  = 50
) (
  input logic              clk,
  input logic              rst,
  joybus_tx_frame_if.slave bus
);
  localparam int unsigned LW = $clog2(MAX_BYTES + 1);
  localparam int unsigned DW = 8 * MAX_BYTES;
  localparam int unsigned CW = $clog2(4 * US_CYC);
  localparam int unsigned TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  localparam logic [CW-1:0] ONE_END   = CW'(US_CYC - 1);
  localparam logic [CW-1:0] TWO_END   = CW'(2 * US_CYC - 1);
  localparam logic [CW-1:0] THREE_END = CW'(3 * US_CYC - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(4 * US_CYC - 1);
  localparam logic [TW-1:0] TURN_END  = TW'(TURN_CYC - 1);

  typedef enum logic [2:0] {IDLE, TURN, BIT_LO, BIT_HI, STOP_LO, STOP_HI} state_t;

  state_t        state, next_state;
  logic [DW-1:0] data_q;
  logic [7:0]    cur_byte;
  logic [LW-1:0] len_q, byte_idx;
  logic          mode_q;
  logic [2:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;

  logic start_req, len_ok, accept, reject;
  logic lo_done, bit_done, last_bit, stop_lo_done, stop_hi_done, turn_done;
  logic jb_tx_d, jb_tx_sel_d, tx_busy_d, tx_done_d, tx_err_d;

  // Start qualification and slot-end decode
  always_comb begin
    cur_byte     = data_q[7:0];
    start_req    = bus.tx_start | (bus.rx_done & bus.auto_arm);
    len_ok       = (bus.tx_len != '0) && (bus.tx_len <= LW'(MAX_BYTES));
    accept       = (state == IDLE) && start_req && len_ok;
    reject       = (state == IDLE) && start_req && !len_ok;
    lo_done      = (cnt == (cur_byte[bit_idx] ? ONE_END : THREE_END));
    bit_done     = (cnt == BIT_END);
    last_bit     = (bit_idx == 3'd0) && (byte_idx == len_q - LW'(1));
    stop_lo_done = (cnt == (mode_q ? TWO_END : ONE_END));
    stop_hi_done = (cnt == ONE_END);
    turn_done    = (tcnt == TURN_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = bus.tx_start ? BIT_LO : TURN;
      TURN:    if (turn_done) next_state = BIT_LO;
      BIT_LO:  if (lo_done) next_state = BIT_HI;
      BIT_HI:  if (bit_done) next_state = last_bit ? STOP_LO : BIT_LO;
      STOP_LO: if (stop_lo_done) next_state = STOP_HI;
      STOP_HI: if (stop_hi_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so the flops line up with it
  always_comb begin
    jb_tx_sel_d = 1'b0;
    jb_tx_d     = 1'b1;
    tx_busy_d   = 1'b0;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;
    jb_tx_sel_d = (next_state == BIT_LO) || (next_state == BIT_HI) ||
                  (next_state == STOP_LO) || (next_state == STOP_HI);
    jb_tx_d     = !((next_state == BIT_LO) || (next_state == STOP_LO));
    tx_busy_d   = (next_state != IDLE);
    tx_done_d   = (state == STOP_HI) && (next_state == IDLE);
    tx_err_d    = reject;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.jb_tx     <= 1'b1;
      bus.jb_tx_sel <= 1'b0;
      bus.tx_busy   <= 1'b0;
      bus.tx_done   <= 1'b0;
      bus.tx_err    <= 1'b0;
    end else begin
      bus.jb_tx     <= jb_tx_d;
      bus.jb_tx_sel <= jb_tx_sel_d;
      bus.tx_busy   <= tx_busy_d;
      bus.tx_done   <= tx_done_d;
      bus.tx_err    <= tx_err_d;
    end
  end

  // Frame latch, slot/bit/byte counters; the payload shifts down one byte per byte sent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      bit_idx  <= '0;
      byte_idx <= '0;
      cnt      <= '0;
      tcnt     <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          data_q   <= bus.tx_data;
          len_q    <= bus.tx_len;
          mode_q   <= bus.stop_mode;
          bit_idx  <= 3'd7;
          byte_idx <= '0;
          cnt      <= '0;
          tcnt     <= '0;
        end
        TURN:   if (!turn_done) tcnt <= tcnt + TW'(1);
        BIT_LO: cnt <= cnt + CW'(1);
        BIT_HI: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx != 3'd0) begin
              bit_idx <= bit_idx - 3'd1;
            end else if (!last_bit) begin
              bit_idx  <= 3'd7;
              byte_idx <= byte_idx + LW'(1);
              data_q   <= data_q >> 8;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP_LO: cnt <= stop_lo_done ? '0 : cnt + CW'(1);
        STOP_HI: cnt <= stop_hi_done ? '0 : cnt + CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_joybus_tx_frame.sv
// Bench for joybus_tx_frame: line monitor decodes each frame and checks it
// against expectations queued when the stimulus issues a start.
module tb_joybus_tx_frame;
  localparam int unsigned MAXB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  joybus_tx_frame_if #(.MAX_BYTES(MAXB)) bus ();

  joybus_tx_frame #(.US_CYC(25), .MAX_BYTES(MAXB), .TURN_CYC(50)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          is_err;
    int          cyc;
    int          len;
    logic [63:0] data;
    int          stop_lo;
    int          sel_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- monitor ----------------
  bit   in_frame = 1'b0;
  logic lvl, first_lvl;
  int   run, lo_len, rise_cyc, sel_cnt;
  int   lo_q[$];
  int   hi_q[$];

  function automatic void close_run();
    if (lvl == 1'b0) lo_len = run;
    else begin
      lo_q.push_back(lo_len);
      hi_q.push_back(run);
      lo_len = 0;
    end
  endfunction

  function automatic void close_final();
    if (lvl == 1'b0) begin
      lo_q.push_back(run);
      hi_q.push_back(0);
    end else close_run();
  endfunction

  function automatic void check_frame();
    exp_t        e;
    logic [63:0] dec;
    bit          ok;
    bit          b;
    int          nb;
    if (exp_q.size() == 0) begin
      chk("expect_pending_done", 64'(exp_q.size()), 1);
      return;
    end
    e = exp_q.pop_front();
    chk("done_kind", 64'(e.is_err), 0);
    chk("rise_cyc", 64'(rise_cyc), 64'(e.cyc));
    chk("first_level", 64'(first_lvl), 0);
    chk("sel_cycles", 64'(sel_cnt), 64'(e.sel_cycles));
    chk("done_cyc", 64'(cyc), 64'(rise_cyc + sel_cnt));
    chk("busy_at_done", 64'(bus.tx_busy), 0);
    if (lo_q.size() == 0) begin
      chk("pulse_count", 64'(lo_q.size()), 64'(8 * e.len + 1));
      return;
    end
    nb = lo_q.size() - 1;
    chk("bit_count", 64'(nb), 64'(8 * e.len));
    dec = '0;
    ok  = 1'b1;
    for (int j = 0; j < nb; j++) begin
      b = 1'b0;
      if (lo_q[j] == 25 && hi_q[j] == 75) b = 1'b1;
      else if (!(lo_q[j] == 75 && hi_q[j] == 25)) ok = 1'b0;
      if (j < 64) dec[8 * (j / 8) + 7 - (j % 8)] = b;
    end
    chk("bit_encoding", 64'(ok), 1);
    chk("payload", dec, e.data);
    chk("stop_low", 64'(lo_q[nb]), 64'(e.stop_lo));
    chk("stop_high", 64'(hi_q[nb]), 25);
  endfunction

  function automatic void check_err();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("expect_pending_err", 64'(exp_q.size()), 1);
      return;
    end
    e = exp_q.pop_front();
    chk("err_kind", 64'(e.is_err), 1);
    chk("err_cyc", 64'(cyc), 64'(e.cyc));
    chk("sel_at_err", 64'(bus.jb_tx_sel), 0);
  endfunction

  always @(negedge clk) begin
    if (rst) in_frame = 1'b0;
    else begin
      if (bus.jb_tx_sel) begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          rise_cyc  = cyc;
          sel_cnt   = 0;
          lvl       = bus.jb_tx;
          first_lvl = bus.jb_tx;
          run       = 0;
          lo_len    = 0;
          lo_q.delete();
          hi_q.delete();
        end
        sel_cnt++;
        if (bus.jb_tx !== lvl) begin
          close_run();
          lvl = bus.jb_tx;
          run = 1;
        end else run++;
      end else if (in_frame) begin
        close_final();
        in_frame = 1'b0;
      end
      if (bus.tx_done) check_frame();
      if (bus.tx_err) check_err();
    end
  end

  // ---------------- stimulus ----------------
  function automatic void push_frame(input int c, input logic [63:0] d, input int len,
                                     input bit mode, input int sel_cyc);
    exp_t        e;
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < len; i++) m[8 * i +: 8] = 8'hFF;
    e.is_err     = 1'b0;
    e.cyc        = c;
    e.len        = len;
    e.data       = d & m;
    e.stop_lo    = mode ? 50 : 25;
    e.sel_cycles = sel_cyc;
    exp_q.push_back(e);
  endfunction

  task automatic send(input logic [63:0] d, input int len, input bit mode,
                      input bit expect_it, input int sel_cyc);
    bus.tx_data   = d;
    bus.tx_len    = 4'(len);
    bus.stop_mode = mode;
    bus.tx_start  = 1'b1;
    if (expect_it) push_frame(cyc + 1, d, len, mode, sel_cyc);
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic send_bad(input int len);
    exp_t e;
    bus.tx_len   = 4'(len);
    bus.tx_start = 1'b1;
    e.is_err     = 1'b1;
    e.cyc        = cyc + 1;
    e.len        = 0;
    e.data       = '0;
    e.stop_lo    = 0;
    e.sel_cycles = 0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!bus.tx_done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(bus.tx_done), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    bus.tx_data   = '0;
    bus.tx_len    = '0;
    bus.stop_mode = 1'b0;
    bus.tx_start  = 1'b0;
    bus.auto_arm  = 1'b0;
    bus.rx_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_jb_tx", 64'(bus.jb_tx), 1);
    chk("rst_sel", 64'(bus.jb_tx_sel), 0);
    chk("rst_busy", 64'(bus.tx_busy), 0);
    chk("rst_done", 64'(bus.tx_done), 0);
    chk("rst_err", 64'(bus.tx_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xAA, console stop
    send(64'hAA, 1, 1'b0, 1'b1, 850);
    wait_done(1000);
    @(negedge clk);

    // Three bytes 00,FF,41 with controller stop; upper junk masked by length
    send(64'hDEADBEEF_0041FF00, 3, 1'b1, 1'b1, 2475);
    repeat (500) @(negedge clk);
    bus.tx_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.tx_len    = 4'd2;
    bus.stop_mode = 1'b0;
    bus.tx_start  = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_done(3000);
    @(negedge clk);

    // Invalid lengths
    send_bad(0);
    repeat (3) @(negedge clk);
    send_bad(9);
    repeat (5) @(negedge clk);
    chk("busy_after_reject", 64'(bus.tx_busy), 0);
    chk("sel_after_reject", 64'(bus.jb_tx_sel), 0);

    // Auto-reply after turnaround
    bus.auto_arm  = 1'b1;
    bus.tx_data   = 64'h5A;
    bus.tx_len    = 4'd1;
    bus.stop_mode = 1'b0;
    bus.rx_done   = 1'b1;
    r = cyc;
    push_frame(r + 51, 64'h5A, 1, 1'b0, 850);
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (24) @(negedge clk);
    chk("turn_busy", 64'(bus.tx_busy), 1);
    chk("turn_sel", 64'(bus.jb_tx_sel), 0);
    wait_done(1200);
    @(negedge clk);
    bus.auto_arm = 1'b0;
    bus.rx_done  = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (100) @(negedge clk);
    chk("disarmed_busy", 64'(bus.tx_busy), 0);
    chk("disarmed_sel", 64'(bus.jb_tx_sel), 0);

    // Reset 300 cycles into a frame, then a clean frame
    send(64'hC3C3, 2, 1'b1, 1'b0, 0);
    repeat (299) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_jb_tx", 64'(bus.jb_tx), 1);
    chk("abort_sel", 64'(bus.jb_tx_sel), 0);
    chk("abort_busy", 64'(bus.tx_busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(64'h7E81, 2, 1'b0, 1'b1, 1650);
    wait_done(2000);
    @(negedge clk);

    // Back-to-back: next start on the tx_done cycle
    send(64'h12, 1, 1'b1, 1'b1, 875);
    wait_done(1000);
    send(64'h9C34, 2, 1'b0, 1'b1, 1650);
    wait_done(2000);

    repeat (20) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/joybus_tx_frame.md
Name: joybus_tx_frame

Overview:
Parametrised Joybus line transmitter. It serialises a frame of 1..MAX_BYTES bytes, MSB first, byte 0 first, followed by a selectable console-style or controller-style stop bit. It drives the shared open-drain data line through jb_tx/jb_tx_sel. It supersedes the single-byte command transmitter. New capabilities are multi-byte frames, stop-bit mode selection, and an auto-reply mode that launches after rx_done plus a bus turnaround gap.

Parameters:
US_CYC, 25, clock cycles per 1 us time slot (25 MHz clk).
MAX_BYTES, 8, maximum bytes per frame.
TURN_CYC, 50, idle cycles between rx_done and start of an auto-reply frame.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
tx_data  in  8*MAX_BYTES  frame payload; byte i = tx_data[8*i+7:8*i]; byte 0 sent first.
tx_len  in  $clog2(MAX_BYTES+1)  number of bytes to send.
stop_mode  in  1  0 = console stop (1 us low), 1 = controller stop (2 us low).
tx_start  in  1  single-cycle request to send immediately.
auto_arm  in  1  when 1, an rx_done pulse launches a frame after TURN_CYC.
rx_done  in  1  single-cycle pulse from the receiver at the end of a received frame.
jb_tx  out  1  line level while driven; idle 1.
jb_tx_sel  out  1  1 = transmitter owns the line (tristate enable).
tx_busy  out  1  1 from the accepted start until the tx_done cycle, inclusive of the turnaround wait.
tx_done  out  1  single-cycle pulse at frame end.
tx_err  out  1  single-cycle pulse when a start is rejected.

Behaviour:
- All outputs are registered.
- Reset values: jb_tx=1, jb_tx_sel=0, tx_busy=0, tx_done=0, tx_err=0; FSM=IDLE; counters cleared.
- Asserting rst mid-frame returns to these values immediately; no completion pulse is produced.
- FSM states: IDLE, TURN, BIT_LO, BIT_HI, STOP_LO, STOP_HI.
- Start acceptance (IDLE only):
  - tx_start=1 has priority over rx_done. On acceptance, latch tx_data, tx_len and stop_mode, then go to BIT_LO.
  - Otherwise, rx_done=1 with auto_arm=1: latch the same inputs, go to TURN, and count TURN_CYC cycles with jb_tx_sel=0; then go to BIT_LO.
  - tx_busy=1 from the cycle after acceptance.
- Reject: a start with tx_len==0 or tx_len>MAX_BYTES is rejected.
  - tx_err pulses in the next cycle and the FSM stays in IDLE.
- tx_start or rx_done while busy is ignored: no error, no effect on the frame in flight.
- Latency: a start sampled at posedge k gives jb_tx_sel=1, jb_tx=0 from cycle k+1.
- Data bit, 4*US_CYC cycles:
  - BIT_LO drives jb_tx=0 for 1*US_CYC cycles if the bit is 1, or 3*US_CYC cycles if the bit is 0.
  - BIT_HI drives jb_tx=1 for the remainder of the 4*US_CYC.
- Bit/byte counters: 3-bit bit counter (7 down to 0), byte index 0..tx_len-1. After the last bit of the last byte, go to STOP_LO.
- STOP_LO: jb_tx=0 for 1*US_CYC (stop_mode=0) or 2*US_CYC (stop_mode=1).
- STOP_HI: jb_tx=1 for US_CYC cycles.
- Frame end: in the following cycle jb_tx_sel=0, tx_busy=0, tx_done=1 for one cycle, and the FSM returns to IDLE.
- A new start is accepted on the tx_done cycle.
- jb_tx_sel is 1 for exactly N*32*US_CYC + (S+1)*US_CYC cycles, where N = bytes and S = stop low slots.
- Inputs tx_data, tx_len and stop_mode may change freely after acceptance with no effect on the frame in flight.
- Slot counter width: $clog2(4*US_CYC). No arithmetic wrap is permitted in any counter.

Test Plan:
- Reset, then tx_start at cycle k with tx_len=1, tx_data[7:0]=8'hAA, stop_mode=0 ->
  - jb_tx_sel high cycles k+1..k+850.
  - Bit 7: low 25 cycles, high 75.
  - Bit 6: low 75 cycles, high 25.
  - Pattern alternates through bit 0.
  - Stop: low 25, high 25.
  - tx_done single pulse at k+851.
- tx_len=3, bytes 0x00,0xFF,0x41, stop_mode=1 ->
  - 24 bits decoded MSB first match the payload.
  - Stop low 50 cycles.
  - Total jb_tx_sel high = 2475 cycles.
  - One tx_done pulse.
- auto_arm=1, rx_done pulse at cycle r, tx_len=1 ->
  - jb_tx_sel stays 0 through r+50.
  - First low at r+51.
  - auto_arm=0 with the same pulse gives no activity.
- tx_start pulsed mid-frame, and tx_start with tx_len=0 or tx_len=9 ->
  - Mid-frame pulse: frame is unaffected.
  - Invalid lengths: tx_err pulse one cycle later, jb_tx_sel stays 0, no tx_done.
- rst asserted 300 cycles into a frame ->
  - Same cycle: jb_tx=1, jb_tx_sel=0, tx_busy=0.
  - No tx_done.
  - Next tx_start sends a correct full frame.
- tx_start asserted on the tx_done cycle ->
  - Second frame begins next cycle.
  - Line encoding is correct back-to-back.
